// File: rtl/if1_fetch_ctrl.sv
// if1_fetch_ctrl: IF1 fetch PC, single-outstanding ICache requests, 2-entry instruction buffer.
// Define IF1_PRE_BRANCH_EN to redirect fpc on returned B/BL instructions.
module if1_fetch_ctrl #(
    parameter int WORD = 32,
    parameter logic [WORD-1:0] PC_RST = 32'h1c000000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [WORD-1:0] redirect_pc,
    output logic            icache_req,
    output logic [WORD-1:0] icache_addr,
    input  logic            icache_ready,
    input  logic            icache_resp_valid,
    input  logic [WORD-1:0] icache_resp_inst,
    output logic            out_valid,
    output logic [WORD-1:0] out_pc,
    output logic [WORD-1:0] out_inst
);
    typedef enum logic [1:0] {REQ, WAIT, DROP} state_t;
    state_t state, state_nxt;
    logic [WORD-1:0] fpc, fpc_nxt, req_pc, target;
    logic [WORD-1:0] pc0, pc1, inst0, inst1, pc0_nxt, pc1_nxt, inst0_nxt, inst1_nxt;
    logic v0, v1, v0_nxt, v1_nxt, keep0, hs, push, pop, busy;
    assign busy        = state != REQ;
    assign icache_req  = ~rst & ~busy & ~(v0 & v1);
    assign icache_addr = fpc;
    assign hs          = icache_req & icache_ready;
    assign push        = icache_resp_valid & (state == WAIT) & ~redirect_valid;
    assign pop         = v0 & ~stall & ~redirect_valid;
    assign out_valid   = v0;
    assign out_pc      = v0 ? pc0 : '0;
    assign out_inst    = v0 ? inst0 : '0;
`ifdef IF1_PRE_BRANCH_EN
    logic is_b;
    assign is_b   = icache_resp_inst[31:27] == 5'b01010;
    assign target = req_pc + (is_b ? {{(WORD-28){icache_resp_inst[9]}}, icache_resp_inst[9:0],
                                      icache_resp_inst[25:10], 2'b00} : WORD'(4));
`else
    assign target = req_pc + WORD'(4);
`endif
    always_comb begin
        state_nxt = state;
        fpc_nxt   = redirect_valid ? redirect_pc : push ? target : fpc;
        if (redirect_valid)
            state_nxt = busy ? (icache_resp_valid ? REQ : DROP) : (hs ? DROP : REQ);
        else if (!busy)
            state_nxt = hs ? WAIT : REQ;
        else if (icache_resp_valid)
            state_nxt = REQ;
    end
    // Entries surviving a pop shift toward the head; a push fills the first free slot.
    always_comb begin
        keep0     = pop ? v1 : v0;
        v0_nxt    = ~redirect_valid & (keep0 | push);
        v1_nxt    = ~redirect_valid & ((v1 & ~pop) | (push & keep0));
        pc0_nxt   = keep0 ? (pop ? pc1 : pc0) : req_pc;
        inst0_nxt = keep0 ? (pop ? inst1 : inst0) : icache_resp_inst;
        pc1_nxt   = (push & keep0) ? req_pc : pc1;
        inst1_nxt = (push & keep0) ? icache_resp_inst : inst1;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= REQ;
            fpc    <= PC_RST;
            req_pc <= PC_RST;
            v0     <= 1'b0;
            v1     <= 1'b0;
            pc0    <= '0;
            pc1    <= '0;
            inst0  <= '0;
            inst1  <= '0;
        end else begin
            state  <= state_nxt;
            fpc    <= fpc_nxt;
            req_pc <= hs ? fpc : req_pc;
            v0     <= v0_nxt;
            v1     <= v1_nxt;
            pc0    <= pc0_nxt;
            pc1    <= pc1_nxt;
            inst0  <= inst0_nxt;
            inst1  <= inst1_nxt;
        end
    end
endmodule
